mchan_rr_req_arbiter: RTL and testbench

- Shares one mchan request port (e.g. TCDM or EXT command channel) between N_REQ requesters with a round-robin policy.
- Holds a registered priority pointer that advances only on an accepted transfer.
- Optionally locks the grant for multi-beat bursts, delimited by last_i.
- Sits between the mchan channel queues and the single downstream command/transaction port.

---
 rtl/mchan_rr_req_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mchan_rr_req_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mchan_rr_req_arbiter.sv
// mchan_rr_req_arbiter
// Round-robin arbiter that shares one mchan command port between N_REQ
// requesters. The request/payload path is combinational; the priority
// pointer, burst lock state and lock owner are registered and only change
// on an accepted downstream transfer (req_o & gnt_i).
//
// Optional feature: define MCHAN_RR_ARB_LOCK_EN to hold the grant on one
// requester across a multi-beat burst delimited by last_i. Without it every
// handshake is treated as a last beat and re-arbitrates.
module mchan_rr_req_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] data_i,
  input  logic [N_REQ-1:0]            last_i,
  output logic [N_REQ-1:0]            gnt_o,
  output logic                        req_o,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic                        last_o,
  output logic [ID_WIDTH-1:0]         id_o,
  input  logic                        gnt_i,
  output logic [ID_WIDTH-1:0]         rr_ptr_o,
  output logic                        locked_o
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e                state_r;
  logic [ID_WIDTH-1:0]   rr_ptr_r;
  logic [ID_WIDTH-1:0]   lock_id_r;

  logic [ID_WIDTH-1:0]   winner_s;
  logic [ID_WIDTH-1:0]   sel_id_s;
  logic                  req_s;
  logic                  hs_s;
  logic                  eff_last_s;
  logic [DATA_WIDTH-1:0] data_s;
  logic                  last_s;
  logic [N_REQ-1:0]      gnt_s;

  // Index arithmetic modulo N_REQ without a divider: both operands are
  // already below N_REQ, so a single conditional subtract wraps correctly
  // even when N_REQ is not a power of two.
  function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                   input int unsigned          off);
    int unsigned sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end else begin
      sum = sum;
    end
    return ID_WIDTH'(sum);
  endfunction

  // Round-robin scan: walk offsets from farthest to nearest so the nearest
  // requesting index (starting at rr_ptr) is the final assignment.
  always_comb begin
    winner_s = rr_ptr_r;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (req_i[wrap_add(rr_ptr_r, off)]) begin
        winner_s = wrap_add(rr_ptr_r, off);
      end else begin
        winner_s = winner_s;
      end
    end
  end

  // Select the active requester: the lock owner during a burst, otherwise
  // the round-robin winner. Downstream request is suppressed during reset.
  always_comb begin
    sel_id_s = winner_s;
    req_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        sel_id_s = winner_s;
        req_s    = |req_i;
      end
      ST_LOCKED: begin
        sel_id_s = lock_id_r;
        req_s    = req_i[lock_id_r];
      end
      default: begin
        sel_id_s = winner_s;
        req_s    = 1'b0;
      end
    endcase
    if (!rst_n) begin
      req_s = 1'b0;
    end else begin
      req_s = req_s;
    end
  end

  // Payload/last mux and one-hot grant steering toward the selected index.
  always_comb begin
    data_s = {DATA_WIDTH{1'b0}};
    last_s = 1'b0;
    gnt_s  = {N_REQ{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      if (ID_WIDTH'(k) == sel_id_s) begin
        data_s   = data_i[k*DATA_WIDTH +: DATA_WIDTH];
        last_s   = last_i[k];
        gnt_s[k] = hs_s;
      end else begin
        gnt_s[k] = 1'b0;
      end
    end
  end

  assign hs_s = req_s & gnt_i;

`ifdef MCHAN_RR_ARB_LOCK_EN
  assign eff_last_s = last_s;
  assign locked_o   = (state_r == ST_LOCKED);
`else
  // Without burst locking every accepted beat closes the transaction.
  assign eff_last_s = 1'b1;
  assign locked_o   = 1'b0;
`endif

  // Arbitration state: pointer advances past the served requester on the
  // last beat; a non-last beat latches the owner and enters the lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      rr_ptr_r  <= {ID_WIDTH{1'b0}};
      lock_id_r <= {ID_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (hs_s) begin
            if (eff_last_s) begin
              rr_ptr_r <= wrap_add(winner_s, 32'd1);
            end else begin
              state_r   <= ST_LOCKED;
              lock_id_r <= winner_s;
            end
          end
        end
        ST_LOCKED: begin
          if (hs_s && eff_last_s) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= wrap_add(lock_id_r, 32'd1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_o    = req_s;
  assign gnt_o    = gnt_s;
  assign data_o   = data_s;
  assign last_o   = last_s;
  assign id_o     = sel_id_s;
  assign rr_ptr_o = rr_ptr_r;

endmodule

// File: tb/tb_mchan_rr_req_arbiter.sv
// Self-checking bench for mchan_rr_req_arbiter: directed scenarios followed
// by random traffic, compared against a queue-free behavioural model of the
// round-robin/burst-lock rules. A second small instance covers N_REQ=3.
module tb_mchan_rr_req_arbiter;

`ifdef MCHAN_RR_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req, last, gnt_o;
  logic [N*DW-1:0] data;
  logic          gnt, req_o, last_o, locked_o;
  logic [DW-1:0] data_o;
  logic [1:0]    id_o, rr_ptr_o;

  logic [2:0]    req3, last3, gnt_o3;
  logic [3*DW-1:0] data3;
  logic          gnt3, req_o3, last_o3, locked_o3;
  logic [DW-1:0] data_o3;
  logic [1:0]    id_o3, rr_ptr_o3;

  int passed = 0;
  int total  = 0;

  // reference model state
  int m_ptr    = 0;
  bit m_locked = 1'b0;
  int m_lock   = 0;

  always #5 clk = ~clk;

  mchan_rr_req_arbiter #(.N_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .data_i(data), .last_i(last),
    .gnt_o(gnt_o), .req_o(req_o), .data_o(data_o), .last_o(last_o),
    .id_o(id_o), .gnt_i(gnt), .rr_ptr_o(rr_ptr_o), .locked_o(locked_o)
  );

  mchan_rr_req_arbiter #(.N_REQ(3), .DATA_WIDTH(DW)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_i(req3), .data_i(data3), .last_i(last3),
    .gnt_o(gnt_o3), .req_o(req_o3), .data_o(data_o3), .last_o(last_o3),
    .id_o(id_o3), .gnt_i(gnt3), .rr_ptr_o(rr_ptr_o3), .locked_o(locked_o3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Which requester the rules say is being served this cycle.
  function automatic int m_sel(input logic [N-1:0] r);
    if (m_locked) return m_lock;
    for (int k = 0; k < N; k++) begin
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return m_ptr;
  endfunction

  // One clock of traffic on the main instance: drive, check, update model.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic g);
    int s;
    logic er;
    logic [N-1:0] eg;
    bit eff_last;
    @(negedge clk);
    req = r; last = l; gnt = g;
    for (int k = 0; k < N; k++) data[k*DW +: DW] = $urandom;
    #1;
    s  = m_sel(r);
    er = m_locked ? r[s] : (r != '0);
    eg = (er && g) ? (4'b0001 << s) : 4'b0000;
    chk("rr_ptr", rr_ptr_o, m_ptr);
    chk("locked", locked_o, m_locked);
    chk("req_o", req_o, er);
    chk("gnt_o", gnt_o, eg);
    chk("id_o", id_o, s);
    if (er) begin
      chk("data_o", data_o, data[s*DW +: DW]);
      chk("last_o", last_o, l[s]);
    end
    if (er && g) begin
      eff_last = LOCK_EN ? l[s] : 1'b1;
      if (eff_last) begin
        m_ptr    = (s + 1) % N;
        m_locked = 1'b0;
      end else begin
        m_locked = 1'b1;
        m_lock   = s;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req = 4'b1111; last = 4'b1111; gnt = 1'b1; data = '0;
    req3 = 3'b000; last3 = 3'b111; gnt3 = 1'b0; data3 = '0;

    // reset: outputs quiet even with all requesting and downstream ready
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rr_ptr", rr_ptr_o, 0);
    chk("rst_locked", locked_o, 0);
    chk("rst_req_o", req_o, 0);
    chk("rst_gnt_o", gnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0000; gnt = 1'b0;

    // N_REQ=3: all requesting, last beats -> 0,1,2,0 and pointer wraps 2->0
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req3 = 3'b111; last3 = 3'b111; gnt3 = 1'b1;
      for (int k = 0; k < 3; k++) data3[k*DW +: DW] = $urandom;
      #1;
      chk("n3_rr_ptr", rr_ptr_o3, i % 3);
      chk("n3_id", id_o3, i % 3);
      chk("n3_gnt", gnt_o3, 3'b001 << (i % 3));
      chk("n3_req_o", req_o3, 1);
      chk("n3_last", last_o3, 1);
      chk("n3_locked", locked_o3, 0);
      chk("n3_data", data_o3, data3[(i % 3)*DW +: DW]);
    end
    @(negedge clk);
    req3 = 3'b000; gnt3 = 1'b0;

    // all requesting, every beat last: 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++) step(4'b1111, 4'b1111, 1'b1);

    // stalled downstream never advances fairness, then accept
    for (int i = 0; i < 5; i++) step(4'b0101, 4'b1111, 1'b0);
    step(4'b0101, 4'b1111, 1'b1);

    // pointer 2 with only 0/1 requesting -> wrap to 0, then 1
    step(4'b1111, 4'b1111, 1'b1);
    step(4'b0011, 4'b1111, 1'b1);
    step(4'b0011, 4'b1111, 1'b1);

    // move pointer to 1, then 3-beat burst from requester 1 with gaps
    step(4'b0001, 4'b1111, 1'b1);
    step(4'b1111, 4'b0000, 1'b1);
    step(4'b1111, 4'b0000, 1'b0);
    step(4'b1111, 4'b0000, 1'b1);
    step(4'b1111, 4'b0010, 1'b1);

    // burst owner drops req mid-burst, others keep requesting
    step(4'b1000, 4'b0000, 1'b1);
    step(4'b0111, 4'b0000, 1'b1);
    step(4'b1111, 4'b1111, 1'b1);

    // lock onto requester 2, then asynchronous reset mid-burst
    step(4'b0100, 4'b0000, 1'b1);
    step(4'b1111, 4'b0000, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_locked", locked_o, 0);
    chk("midrst_rr_ptr", rr_ptr_o, 0);
    chk("midrst_req_o", req_o, 0);
    chk("midrst_gnt_o", gnt_o, 0);
    m_ptr = 0; m_locked = 1'b0; m_lock = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, 4'b1111, 1'b1);

    // random traffic, bursts ended with roughly 1-in-3 probability
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] rl;
      for (int k = 0; k < N; k++) rl[k] = ($urandom_range(2, 0) == 0);
      step(4'($urandom), rl, 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
